// File: rtl/monster_pkg.sv
// Shared slot-bus layout and playfield constants for the
// game logic and the monster renderer.
package monster_pkg;

  localparam int MONSTERS    = 12;
  localparam int SLOT_W      = 19;
  localparam int VALID_LSB   = 0;
  localparam int DIR_LSB     = 1;
  localparam int X_LSB       = 3;
  localparam int Y_LSB       = 11;
  localparam int SPRITE_W    = 16;
  localparam int SPRITE_H    = 16;
  localparam int SCALE_SHIFT = 1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Playfield geometry in game units
  localparam logic [7:0] PLAY_X_MIN   = 8'd8;
  localparam logic [7:0] PLAY_X_MAX   = 8'd232;
  localparam logic [7:0] PLAY_Y_MIN   = 8'd8;
  localparam logic [7:0] PLAY_Y_MAX   = 8'd216;
  localparam logic [7:0] LANE_UP_X    = 8'd56;
  localparam logic [7:0] LANE_DOWN_X  = 8'd184;
  localparam logic [7:0] LANE_LEFT_Y  = 8'd64;
  localparam logic [7:0] LANE_RIGHT_Y = 8'd160;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [1:0] dir;
    logic       valid;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READY
  } state_e;

  function automatic slot_t unpack_slot(
    input logic [SLOT_W-1:0] raw,
    input logic              alive
  );
    slot_t s;
    s.valid = raw[VALID_LSB] & alive;
    s.dir   = raw[DIR_LSB +: 2];
    s.x     = raw[X_LSB +: 8];
    s.y     = raw[Y_LSB +: 8];
    return s;
  endfunction

endpackage

// File: rtl/monster_span_check.sv
// 9-bit inclusive range compare of a game coordinate against
// a sprite span, plus the 4-bit sprite-local offset.
module monster_span_check #(
  parameter int SIZE = 16
) (
  input  logic [8:0] i_g,
  input  logic [7:0] i_lo,
  output logic       o_in,
  output logic [3:0] o_off
);

  logic [8:0] w_lo;
  logic [8:0] w_hi;

  // Bounds kept 9 bits wide so spans near 255 never wrap
  assign w_lo  = {1'b0, i_lo};
  assign w_hi  = w_lo + 9'(SIZE - 1);
  assign o_in  = (i_g >= w_lo) && (i_g <= w_hi);
  assign o_off = i_g[3:0] - i_lo[3:0];

endmodule

// File: rtl/monster_renderer.sv
// Per-pixel monster sprite coverage from a per-frame snapshot
// of the slot bus, with a per-line slot pre-scan.
module monster_renderer
  import monster_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MONSTERS*SLOT_W-1:0] state_monsters,
  input  logic                       alive,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic [9:0]                 line_y,
  input  logic                       pix_en,
  input  logic [9:0]                 pix_x,
  output logic                       hit,
  output logic [3:0]                 hit_slot,
  output logic [1:0]                 hit_dir,
  output logic [3:0]                 hit_u,
  output logic [3:0]                 hit_v,
  output logic                       line_ready
);

  localparam logic [3:0] LAST_K = 4'(MONSTERS - 1);

  slot_t               r_snap [MONSTERS];
  logic [MONSTERS-1:0] r_mask;
  logic [3:0]          r_line_v [MONSTERS];
  logic [3:0]          r_k;
  state_e              r_state;
  state_e              w_next;

  logic                r_hit;
  logic [3:0]          r_hit_slot;
  logic [1:0]          r_hit_dir;
  logic [3:0]          r_hit_u;
  logic [3:0]          r_hit_v;

  logic                w_ready;
  logic                w_scan;
  logic [8:0]          w_gx;
  logic [8:0]          w_gy;
  slot_t               w_cur;
  logic                w_y_in;
  logic [3:0]          w_y_off;
  logic [MONSTERS-1:0] w_x_in;
  logic [3:0]          w_x_off [MONSTERS];
  logic [MONSTERS-1:0] w_cand;
  logic                w_hit;
  logic [3:0]          w_sel;

  assign w_gx  = 9'(pix_x >> SCALE_SHIFT);
  assign w_gy  = 9'(line_y >> SCALE_SHIFT);
  assign w_cur = r_snap[r_k];

  // Bus is sampled only here, so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MONSTERS; k++) r_snap[k] <= '0;
    end else if (frame_start) begin
      for (int k = 0; k < MONSTERS; k++)
        r_snap[k] <= unpack_slot(
          state_monsters[k*SLOT_W +: SLOT_W], alive);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (frame_start)
      w_next = ST_IDLE;
    else if (line_start)
      w_next = ST_SCAN;
    else if (r_state == ST_SCAN && r_k == LAST_K)
      w_next = ST_READY;
  end

  always_comb begin
    w_ready = (r_state == ST_READY);
    w_scan  = (r_state == ST_SCAN);
  end

  assign line_ready = w_ready;

  monster_span_check #(.SIZE(SPRITE_H)) u_y_span (
    .i_g   (w_gy),
    .i_lo  (w_cur.y),
    .o_in  (w_y_in),
    .o_off (w_y_off)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_mask <= '0;
      for (int k = 0; k < MONSTERS; k++) r_line_v[k] <= '0;
    end else if (frame_start || line_start) begin
      r_k    <= '0;
      r_mask <= '0;
    end else if (w_scan) begin
      r_k <= (r_k == LAST_K) ? '0 : r_k + 4'd1;
      if (w_cur.valid && w_y_in) begin
        r_mask[r_k]   <= 1'b1;
        r_line_v[r_k] <= w_y_off;
      end
    end
  end

  for (genvar g = 0; g < MONSTERS; g++) begin : g_x
    monster_span_check #(.SIZE(SPRITE_W)) u_x_span (
      .i_g   (w_gx),
      .i_lo  (r_snap[g].x),
      .o_in  (w_x_in[g]),
      .o_off (w_x_off[g])
    );
    assign w_cand[g] = w_ready && r_mask[g] && w_x_in[g];
  end

  // Descending sweep leaves the lowest candidate selected
  always_comb begin
    w_hit = pix_en && (|w_cand);
    w_sel = '0;
    for (int k = MONSTERS - 1; k >= 0; k--)
      if (w_cand[k]) w_sel = 4'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit      <= 1'b0;
      r_hit_slot <= '0;
      r_hit_dir  <= '0;
      r_hit_u    <= '0;
      r_hit_v    <= '0;
    end else begin
      r_hit <= w_hit;
      if (w_hit) begin
        r_hit_slot <= w_sel;
        r_hit_dir  <= r_snap[w_sel].dir;
        r_hit_u    <= w_x_off[w_sel];
        r_hit_v    <= r_line_v[w_sel];
      end else begin
        r_hit_slot <= '0;
        r_hit_dir  <= '0;
        r_hit_u    <= '0;
        r_hit_v    <= '0;
      end
    end
  end

  assign hit      = r_hit;
  assign hit_slot = r_hit_slot;
  assign hit_dir  = r_hit_dir;
  assign hit_u    = r_hit_u;
  assign hit_v    = r_hit_v;

endmodule

// File: tb/tb_monster_renderer.sv
// Directed and randomized checks of monster_renderer against
// a slot-list reference model.
module tb_monster_renderer;
  import monster_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic [MONSTERS*SLOT_W-1:0] state_monsters;
  logic                       alive;
  logic                       frame_start;
  logic                       line_start;
  logic [9:0]                 line_y;
  logic                       pix_en;
  logic [9:0]                 pix_x;
  logic                       hit;
  logic [3:0]                 hit_slot;
  logic [1:0]                 hit_dir;
  logic [3:0]                 hit_u;
  logic [3:0]                 hit_v;
  logic                       line_ready;

  monster_renderer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .state_monsters (state_monsters),
    .alive          (alive),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .line_y         (line_y),
    .pix_en         (pix_en),
    .pix_x          (pix_x),
    .hit            (hit),
    .hit_slot       (hit_slot),
    .hit_dir        (hit_dir),
    .hit_u          (hit_u),
    .hit_v          (hit_v),
    .line_ready     (line_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: frame snapshot as plain integers
  bit m_valid [MONSTERS];
  int m_dir   [MONSTERS];
  int m_x     [MONSTERS];
  int m_y     [MONSTERS];
  int m_gy    = 0;
  bit m_ready = 0;
  int m_left  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hit"},  32'(hit),        0);
    chk({tag, "_slot"}, 32'(hit_slot),   0);
    chk({tag, "_dir"},  32'(hit_dir),    0);
    chk({tag, "_u"},    32'(hit_u),      0);
    chk({tag, "_v"},    32'(hit_v),      0);
    chk({tag, "_rdy"},  32'(line_ready), 0);
  endtask

  task automatic step();
    @(negedge clk);
    if (!m_ready && m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ready = 1;
    end
  endtask

  task automatic set_slot(input int k, input bit v,
                          input int d, input int x, input int y);
    state_monsters[k*SLOT_W +: SLOT_W] =
      {8'(y), 8'(x), 2'(d), v};
  endtask

  task automatic clear_bus();
    state_monsters = '0;
  endtask

  task automatic model_snapshot(input bit a);
    for (int k = 0; k < MONSTERS; k++) begin
      m_valid[k] = state_monsters[k*SLOT_W] && a;
      m_dir[k]   = int'(state_monsters[k*SLOT_W+1 +: 2]);
      m_x[k]     = int'(state_monsters[k*SLOT_W+3 +: 8]);
      m_y[k]     = int'(state_monsters[k*SLOT_W+11 +: 8]);
    end
    m_ready = 0;
    m_left  = 0;
  endtask

  task automatic do_frame(input bit a);
    pix_en      = 1'b0;
    alive       = a;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    model_snapshot(a);
  endtask

  task automatic do_line(input int ly);
    pix_en     = 1'b0;
    line_y     = 10'(ly);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    m_gy    = ly / 2;
    m_ready = 0;
    m_left  = MONSTERS;
  endtask

  task automatic wait_scan();
    repeat (MONSTERS - 1) step();
    chk("scan_pre", 32'(line_ready), 32'(m_ready));
    step();
    chk("scan_done", 32'(line_ready), 32'(m_ready));
  endtask

  task automatic pix(input string tag, input int px, input bit en);
    int gx;
    bit e_hit;
    int e_slot, e_dir, e_u, e_v;
    gx = px / 2;
    e_hit = 0; e_slot = 0; e_dir = 0; e_u = 0; e_v = 0;
    if (en && m_ready)
      for (int k = 0; k < MONSTERS; k++)
        if (!e_hit && m_valid[k] &&
            m_gy >= m_y[k] && m_gy <= m_y[k] + SPRITE_H - 1 &&
            gx >= m_x[k] && gx <= m_x[k] + SPRITE_W - 1) begin
          e_hit  = 1;
          e_slot = k;
          e_dir  = m_dir[k];
          e_u    = gx - m_x[k];
          e_v    = m_gy - m_y[k];
        end
    pix_x  = 10'(px);
    pix_en = en;
    step();
    chk({tag, "_hit"},  32'(hit),        32'(e_hit));
    chk({tag, "_slot"}, 32'(hit_slot),   32'(e_slot));
    chk({tag, "_dir"},  32'(hit_dir),    32'(e_dir));
    chk({tag, "_u"},    32'(hit_u),      32'(e_u));
    chk({tag, "_v"},    32'(hit_v),      32'(e_v));
    chk({tag, "_rdy"},  32'(line_ready), 32'(m_ready));
  endtask

  function automatic int near(input int base, input int span);
    int r;
    r = base + $urandom_range(0, span + 1) - 1;
    return (r < 0) ? 0 : r;
  endfunction

  initial begin
    rst_n          = 1'b0;
    state_monsters = '0;
    alive          = 1'b0;
    frame_start    = 1'b0;
    line_start     = 1'b0;
    line_y         = '0;
    pix_en         = 1'b0;
    pix_x          = '0;
    for (int k = 0; k < MONSTERS; k++) begin
      m_valid[k] = 0; m_dir[k] = 0; m_x[k] = 0; m_y[k] = 0;
    end
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single sprite, left and right edges
    clear_bus();
    set_slot(0, 1, 2, 131, 105);
    do_frame(1);
    do_line(210);
    wait_scan();
    pix("s0_left", 262, 1);
    pix("s0_right", 292, 1);
    pix("s0_past", 294, 1);
    pix("s0_noen", 262, 0);

    // Overlap: lower slot index wins
    clear_bus();
    set_slot(3, 1, 1, 73, 47);
    set_slot(5, 1, 1, 73, 47);
    do_frame(1);
    do_line(100);
    wait_scan();
    pix("ovl", 150, 1);

    // alive=0 frame hides everything
    for (int k = 0; k < MONSTERS; k++)
      set_slot(k, 1, k % 4, 20 * k, 10 * k);
    do_frame(0);
    for (int l = 0; l < 3; l++) begin
      do_line(40 * l + 2);
      wait_scan();
      for (int p = 0; p < 4; p++)
        pix("dead", 80 * l + 4 * p, 1);
    end
    do_frame(1);
    for (int l = 0; l < 3; l++) begin
      do_line(40 * l + 2);
      wait_scan();
      for (int p = 0; p < 4; p++)
        pix("alive", 80 * l + 4 * p, 1);
    end

    // Bus change mid-frame is ignored until next frame
    clear_bus();
    set_slot(0, 1, 2, 131, 105);
    do_frame(1);
    set_slot(0, 1, 2, 14, 105);
    do_line(210);
    wait_scan();
    pix("tear_old", 262, 1);
    pix("tear_new", 28, 1);
    do_frame(1);
    do_line(210);
    wait_scan();
    pix("moved_new", 28, 1);
    pix("moved_old", 262, 1);

    // Sprite near 255 must not wrap
    clear_bus();
    set_slot(0, 1, 3, 250, 250);
    do_frame(1);
    do_line(520);
    wait_scan();
    pix("hi_in", 520, 1);
    pix("hi_edge", 531, 1);
    pix("hi_out", 532, 1);
    pix("hi_wrap", 10, 1);
    do_line(0);
    wait_scan();
    pix("hi_ywrap", 520, 1);

    // Restart mid-scan: nothing until the new scan completes
    clear_bus();
    set_slot(0, 1, 2, 131, 105);
    do_frame(1);
    do_line(210);
    repeat (5) step();
    do_line(210);
    for (int i = 0; i < MONSTERS; i++)
      pix("restart", 262, 1);
    pix("restart_ok", 262, 1);

    // Coincident frame_start and line_start: frame wins
    pix_en      = 1'b0;
    frame_start = 1'b1;
    line_start  = 1'b1;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    model_snapshot(1);
    chk("coinc_rdy0", 32'(line_ready), 0);
    repeat (MONSTERS + 3) step();
    chk("coinc_rdy1", 32'(line_ready), 0);
    pix("coinc_pix", 262, 1);

    // Async reset with a hit pending in the middle of a scan
    do_line(210);
    wait_scan();
    pix_x      = 10'd262;
    pix_en     = 1'b1;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    chk("pend_hit", 32'(hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_snapshot(0);
    do_line(210);
    wait_scan();
    pix("post_rst", 262, 1);
    do_frame(1);
    do_line(210);
    wait_scan();
    pix("post_rst_frame", 262, 1);

    // Randomized frames
    for (int f = 0; f < 15; f++) begin
      for (int k = 0; k < MONSTERS; k++) begin
        int x, y;
        x = ($urandom_range(0, 3) == 0) ?
            $urandom_range(240, 255) : $urandom_range(0, 255);
        y = ($urandom_range(0, 3) == 0) ?
            $urandom_range(240, 255) : $urandom_range(0, 255);
        set_slot(k, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), x, y);
      end
      do_frame($urandom_range(0, 7) != 0);
      for (int l = 0; l < 3; l++) begin
        int kk, ly;
        kk = $urandom_range(0, MONSTERS - 1);
        ly = 2 * near(m_y[kk], SPRITE_H) + $urandom_range(0, 1);
        do_line(ly);
        wait_scan();
        for (int p = 0; p < 8; p++) begin
          int kp, px;
          kp = $urandom_range(0, MONSTERS - 1);
          px = 2 * near(m_x[kp], SPRITE_W) + $urandom_range(0, 1);
          pix("rand", px, $urandom_range(0, 5) != 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/monster_renderer.md
Name: monster_renderer

Overview:
- Display-side consumer of the packed 12-slot monster state bus produced by the game state machine.
- Snapshots the bus once per frame, pre-scans the slots during each horizontal blank, then reports, per pixel, whether a live monster sprite covers it.
- Also reports which slot and direction covers the pixel, and the sprite-local coordinates, so the downstream sprite ROM and colour mux can draw it.
- Sits between the game logic and the VGA pixel pipeline.

Parameters:
- MONSTERS, 12: number of slots on the bus.
- SLOT_W, 19: bits per slot. Layout: [0] valid, [2:1] dir, [10:3] x, [18:11] y.
- SPRITE_W, 16: sprite width in game units.
- SPRITE_H, 16: sprite height in game units.
- SCALE_SHIFT, 1: game unit = pixel >> SCALE_SHIFT.

Ports:
- clk, in, 1: single clock, the pixel clock.
- rst_n, in, 1: asynchronous, active-low reset.
- state_monsters, in, MONSTERS*SLOT_W: packed slot bus from the game logic, in a different clock domain.
- alive, in, 1: game-running flag.
- frame_start, in, 1: one-cycle pulse at the start of vertical blank.
- line_start, in, 1: one-cycle pulse at the start of horizontal blank.
- line_y, in, 10: pixel row of the next line to be displayed.
- pix_en, in, 1: active-video qualifier.
- pix_x, in, 10: current pixel column.
- hit, out, 1: a sprite covers the pixel.
- hit_slot, out, 4: index of the covering slot.
- hit_dir, out, 2: dir field of that slot.
- hit_u, out, 4: sprite-local column.
- hit_v, out, 4: sprite-local row.
- line_ready, out, 1: the line pre-scan is complete.

Behaviour:
- Reset (async, rst_n=0): hit, hit_slot, hit_dir, hit_u, hit_v and line_ready are 0. FSM goes to IDLE. Snapshot registers and line_mask are cleared.
- Snapshot:
  - On frame_start, register all state_monsters bits.
  - If alive=0 at that edge, store all valid bits as 0.
  - The snapshot is held constant until the next frame_start (tear-free).
  - No other sampling of the bus is permitted.
- FSM states: IDLE, SCAN, READY.
  - IDLE/READY -> SCAN on line_start. Clear line_mask, set k=0, set line_ready=0.
  - In SCAN, one slot per cycle, k = 0..MONSTERS-1. Compute gy = line_y >> SCALE_SHIFT.
  - Set line_mask[k] if valid[k] && y[k] <= gy <= y[k]+SPRITE_H-1. When set, store v[k] = gy - y[k] (4 bits).
  - After k=MONSTERS-1: -> READY, line_ready=1. Scan takes exactly MONSTERS cycles.
  - line_start during SCAN: restart at k=0 with line_mask cleared.
  - frame_start in any state: snapshot, then -> IDLE with line_mask cleared and line_ready=0. It has priority over a coincident line_start, which is dropped.
- Pixel path, 1-cycle registered latency:
  - gx = pix_x >> SCALE_SHIFT.
  - Candidate k: line_ready && line_mask[k] && x[k] <= gx <= x[k]+SPRITE_W-1.
  - hit = pix_en && any candidate.
  - Lowest-index candidate wins. Its slot, dir, u = gx - x[k], and v[k] are registered.
  - When hit=0, hit_slot, hit_dir, hit_u and hit_v are driven 0.
- Arithmetic:
  - Range bounds are computed 9 bits wide (x+SPRITE_W-1, y+SPRITE_H-1), so a sprite near coordinate 255 never wraps to 0.
  - gx and gy are truncated to 9 bits. Values above 255 compare correctly against the 9-bit bounds.
- Timing requirement: horizontal blank must be at least MONSTERS+1 clk cycles. If active video starts while still in SCAN, hit stays 0 for that line.

Decomposition:
- Shared package (monster_pkg) holds:
  - MONSTERS, SLOT_W.
  - Field offsets: VALID_LSB=0, DIR_LSB=1, X_LSB=3, Y_LSB=11.
  - Dir encoding: 00 up-lane, 01 down-lane, 10 left-lane, 11 right-lane.
  - SPRITE_W, SPRITE_H.
  - The game's position constants, so the game logic and this renderer stay in sync.
- One sub-module, monster_span_check: a combinational 9-bit range compare returning the in-range flag and the 4-bit offset. It is instantiated for the y pre-scan and MONSTERS times for the x compare.

Test Plan:
- Slot 0 = {valid=1, dir=10, x=131, y=105}, alive=1, frame_start, line_start with line_y=210; wait 12 cycles. Then:
  - pix_x=262: next cycle hit=1, slot=0, dir=10, u=0, v=0.
  - pix_x=292: hit=1, u=15.
  - pix_x=294: hit=0.
- Slots 3 and 5 both {valid=1, dir=01, x=73, y=47}; line_y=100, pix_x=150: hit=1, hit_slot=3, u=2, v=3.
- alive=0 at frame_start with all slots valid: hit=0 for every line and pixel of that frame. Raise alive; after the next frame_start, hits reappear.
- Change state_monsters mid-frame (move slot 0 to x=14): outputs still reflect x=131 until the next frame_start, then reflect x=14.
- Pulse line_start at scan cycle 5 and assert pix_en before 12 further cycles: hit=0 and line_ready=0 until the restarted scan completes. Coincident frame_start+line_start: FSM goes to IDLE, line_ready=0.
- Assert rst_n=0 mid-SCAN with hit=1 pending: all outputs 0 immediately (asynchronously). After release, no hit until a frame_start and line_start have occurred.
